// File: rtl/dmem_sb_pkg.sv
// Shared types and helpers for the data-memory store buffer.
// The coalescing option (STORE_BUF_COALESCE_EN) is implemented in sb_fifo.
package dmem_sb_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  localparam logic [1:0] ARB_LOAD   = 2'd0;
  localparam logic [1:0] ARB_DRAIN  = 2'd1;
  localparam logic [1:0] ARB_BYPASS = 2'd2;
  localparam logic [1:0] ARB_IDLE   = 2'd3;

  // Word stores only, so byte-offset bits never take part in a match.
  function automatic logic word_match(input logic [SB_ADDR_W-1:0] a,
                                      input logic [SB_ADDR_W-1:0] b);
    return a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order circular store FIFO: storage, pointers, occupancy.
// With STORE_BUF_COALESCE_EN defined, a store hitting the youngest entry overwrites it in place.
module sb_fifo
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq,
  input  logic                     pop,
  input  sb_entry_t                wr_entry,
  output sb_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             overwrite;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] tail_last;
  assign tail_last = tail - PTR_W'(1);
  // A youngest entry that is also leaving this cycle cannot be updated; enqueue instead.
  assign overwrite = enq & !empty & word_match(wr_entry.addr, mem[tail_last].addr)
                   & !(pop & (count == CNT_W'(1)));
  assign push      = enq & !overwrite;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= wr_entry;
    end else if (overwrite) begin
      mem[tail_last].data <= wr_entry.data;
    end
  end
`else
  assign overwrite = 1'b0;
  assign push      = enq & !overwrite;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= wr_entry;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign entries = mem;

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the CPU MEM stage and the single-port data RAM/MMIO bus.
// Optional store coalescing is enabled with STORE_BUF_COALESCE_EN (see sb_fifo).
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      cpu_addr_i,
  input  logic [DATA_W-1:0]      cpu_wdata_i,
  input  logic                   cpu_we_i,
  input  logic                   cpu_re_i,
  output logic [DATA_W-1:0]      cpu_rdata_o,
  output logic                   cpu_stall_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  output logic                   mem_we_o,
  input  logic                   mem_ready_i,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [DEPTH];
  sb_entry_t        wr_entry;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [1:0]       arb;
  logic             pop, enq;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0] idx;

  assign wr_entry = '{addr: cpu_addr_i, data: cpu_wdata_i};

  // Loads own the port; otherwise buffered stores drain before any new store goes direct.
  always_comb begin
    arb = ARB_IDLE;
    if (cpu_re_i)      arb = ARB_LOAD;
    else if (!empty)   arb = ARB_DRAIN;
    else if (cpu_we_i) arb = ARB_BYPASS;
  end

  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_we_o    = 1'b0;
    case (arb)
      ARB_DRAIN: begin
        mem_addr_o  = entries[head].addr;
        mem_wdata_o = entries[head].data;
        mem_we_o    = 1'b1;
      end
      ARB_BYPASS: mem_we_o = 1'b1;
      default: ;
    endcase
  end

  assign pop         = (arb == ARB_DRAIN) & mem_ready_i;
  assign cpu_stall_o = cpu_we_i & full & !pop;
  assign enq         = cpu_we_i & !cpu_stall_o
                     & (!empty | ((arb == ARB_BYPASS) & !mem_ready_i));

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && word_match(entries[idx].addr, cpu_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign cpu_rdata_o = fwd_hit ? fwd_data : mem_rdata_i;
  assign count_o     = count;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq      (enq),
    .pop      (pop),
    .wr_entry (wr_entry),
    .entries  (entries),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: expected memory writes and load data go through queues
// checked by monitors; STORE_BUF_COALESCE_EN selects the coalescing expectations.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_we_i;
  logic        cpu_re_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  count_o;

  logic [63:0] exp_q[$];
  logic [31:0] ld_q[$];
  int          checks = 0;
  int          errors = 0;

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_re_i    (cpu_re_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .count_o     (count_o)
  );

  // Clock / reset block; the memory returns a recognisable pattern for its address.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign mem_rdata_i = {16'hC0DE, mem_addr_o[15:0]};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: accepted memory writes and load data.
  always @(negedge clk) begin
    if (mem_we_o && mem_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr_o, mem_wdata_o}, 64'h0);
        if ({mem_addr_o, mem_wdata_o} == 64'h0) begin
          errors++;
          $display("FAIL unexpected_write: actual=write required=none");
        end
      end else begin
        chk("mem_write", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
      end
    end
    if (rst_n && cpu_re_i) begin
      if (ld_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_load: actual=load required=none");
      end else begin
        chk("load_data", {32'h0, cpu_rdata_o}, {32'h0, ld_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    bit accepted = 0;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
    cpu_we_i    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_stall_o) begin
        accepted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!accepted) chk("store_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cpu_we_i = 1'b0;
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] exp_data);
    ld_q.push_back(exp_data);
    cpu_addr_i = a;
    cpu_re_i   = 1'b1;
    @(negedge clk);
    chk("load_no_write", {63'h0, mem_we_o}, 64'd0);
    @(posedge clk); #1;
    cpu_re_i = 1'b0;
  endtask

  task automatic drain_all();
    bit done = 0;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (count_o == 3'd0) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", {63'h0, done}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    cpu_we_i    = 1'b0;
    cpu_re_i    = 1'b0;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count", {61'h0, count_o}, 64'd0);
    chk("reset_mem_we", {63'h0, mem_we_o}, 64'd0);
    chk("reset_stall", {63'h0, cpu_stall_o}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bypass store with memory ready
    exp_q.push_back({32'h100, 32'hAAAA5555});
    cpu_addr_i  = 32'h100;
    cpu_wdata_i = 32'hAAAA5555;
    cpu_we_i    = 1'b1;
    @(negedge clk);
    chk("bypass_we", {63'h0, mem_we_o}, 64'd1);
    chk("bypass_stall", {63'h0, cpu_stall_o}, 64'd0);
    @(posedge clk); #1;
    cpu_we_i = 1'b0;
    @(negedge clk);
    chk("bypass_count", {61'h0, count_o}, 64'd0);
    @(posedge clk); #1;

    // Fill to full, stall, then pop+push on the full buffer with pointer wrap
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'h10 + 32'(4 * i), 32'h11 * 32'(i + 1)});
      sw(32'h10 + 32'(4 * i), 32'h11 * 32'(i + 1));
    end
    @(negedge clk);
    chk("full_count", {61'h0, count_o}, 64'd4);
    @(posedge clk); #1;
    exp_q.push_back({32'h30, 32'h55});
    cpu_addr_i  = 32'h30;
    cpu_wdata_i = 32'h55;
    cpu_we_i    = 1'b1;
    @(negedge clk);
    chk("full_stall", {63'h0, cpu_stall_o}, 64'd1);
    @(posedge clk); #1;
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("full_drain_no_stall", {63'h0, cpu_stall_o}, 64'd0);
    @(posedge clk); #1;
    cpu_we_i = 1'b0;
    @(negedge clk);
    chk("full_swap_count", {61'h0, count_o}, 64'd4);
    @(posedge clk); #1;
    drain_all();

    // Forwarding from buffered stores; youngest match wins
    mem_ready_i = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    exp_q.push_back({32'h20, 32'h2});
`else
    exp_q.push_back({32'h20, 32'h1});
    exp_q.push_back({32'h20, 32'h2});
`endif
    sw(32'h20, 32'h1);
    sw(32'h20, 32'h2);
    lw(32'h20, 32'h2);
    lw(32'h24, 32'hC0DE0024);
    lw(32'h22, 32'h2);
    drain_all();

    // Async reset discards buffered stores
    mem_ready_i = 1'b0;
    sw(32'h50, 32'hA);
    sw(32'h54, 32'hB);
    sw(32'h58, 32'hC);
    @(negedge clk);
    chk("pre_reset_count", {61'h0, count_o}, 64'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", {61'h0, count_o}, 64'd0);
    chk("async_reset_mem_we", {63'h0, mem_we_o}, 64'd0);
    mem_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_count", {61'h0, count_o}, 64'd0);
    @(posedge clk); #1;

    // Same-address stores: coalesced when the option is built in
    mem_ready_i = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    exp_q.push_back({32'h40, 32'h9});
`else
    exp_q.push_back({32'h40, 32'h5});
    exp_q.push_back({32'h40, 32'h9});
`endif
    sw(32'h40, 32'h5);
    sw(32'h40, 32'h9);
    @(negedge clk);
`ifdef STORE_BUF_COALESCE_EN
    chk("coalesce_count", {61'h0, count_o}, 64'd1);
`else
    chk("same_addr_count", {61'h0, count_o}, 64'd2);
`endif
    @(posedge clk); #1;
    drain_all();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("ld_q_empty", 64'(ld_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the CPU MEM stage, between the CPU data-memory outputs (address, store data, write enable, read data) and the single-port data RAM / MMIO bus.
- Holds stores in a small in-order FIFO when the memory side is not ready. Drains them when the port is free.
- Gives loads port priority and forwards load data from buffered stores, so no store is ever lost and no stale load value is ever returned.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; word stores only.

Ports:
- clk  in  1  clock; every flop updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr_i  in  ADDR_W  MEM-stage address (ALU result).
- cpu_wdata_i  in  DATA_W  MEM-stage store data.
- cpu_we_i  in  1  store request this cycle.
- cpu_re_i  in  1  load request this cycle; never asserted together with cpu_we_i.
- cpu_rdata_o  out  DATA_W  load data, combinational, valid in the same cycle as the request.
- cpu_stall_o  out  1  store not accepted this cycle; the CPU must hold the request.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_we_o  out  1  memory write request.
- mem_ready_i  in  1  the write presented this cycle is accepted.
- mem_rdata_i  in  DATA_W  asynchronous read data for mem_addr_o.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular FIFO of {addr, data} entries. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately. full = (count == DEPTH), empty = (count == 0).
- Reset (async, rst_n low): count, head and tail go to 0. Entry contents need no reset. Asserting reset mid-drain discards all buffered stores.
- Outputs after reset: mem_we_o=0, cpu_stall_o=0, count_o=0. mem_addr_o and cpu_rdata_o follow the combinational rules below.
- Port arbitration, combinational, priority order:
  - LOAD: cpu_re_i=1. mem_addr_o=cpu_addr_i, mem_we_o=0. No pop this cycle.
  - DRAIN: not LOAD and not empty. mem_addr_o/mem_wdata_o = head entry, mem_we_o=1. Pop when mem_ready_i=1.
  - BYPASS: empty and cpu_we_i=1. mem_addr_o/mem_wdata_o = CPU store, mem_we_o=1. Enqueue when mem_ready_i=0.
  - IDLE: otherwise. mem_we_o=0, mem_addr_o=cpu_addr_i.
- Enqueue:
  - A store is enqueued when cpu_we_i=1 and the buffer is non-empty, or when it is a BYPASS with mem_ready_i=0.
  - cpu_stall_o = cpu_we_i & full & !(DRAIN & mem_ready_i). A stalled store is neither enqueued nor written.
  - When full, a pop and an enqueue in the same cycle are legal: count is unchanged and both pointers advance.
- Ordering: memory sees stores strictly in program order. A BYPASS never overtakes a buffered entry.
- Forwarding:
  - cpu_rdata_o returns the data of the youngest valid entry whose addr[ADDR_W-1:2] equals cpu_addr_i[ADDR_W-1:2]; otherwise mem_rdata_i.
  - Forwarding covers the entry being popped in that same cycle. A LOAD cycle never pops, so this is consistent.
- Latency:
  - Loads: 0 cycles (combinational).
  - Stores: visible in memory after at most count+1 ready cycles that are not LOAD cycles.
- Addresses are word-aligned; bits [1:0] are ignored on match and passed through on mem_addr_o.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- With the macro defined: a store whose word address matches the youngest entry (tail-1) overwrites that entry's data in place, and count is unchanged. Exception: if that entry is also the head being popped this cycle, the store is enqueued normally.
- Without the macro: every accepted store occupies a new entry.

Decomposition:
- Package dmem_sb_pkg holds:
  - the sb_entry_t typedef {addr, data};
  - the arbitration encoding (LOAD, DRAIN, BYPASS, IDLE as 2-bit localparams);
  - the function for the word-address compare.
- One sub-module, sb_fifo: storage, pointers, count, push/pop/overwrite. The top contains arbitration, stall and forwarding logic.

Test Plan:
- Reset, then sw 0x100=0xAAAA5555 with mem_ready_i=1 -> BYPASS, mem_we_o=1 the same cycle, count_o stays 0.
- mem_ready_i=0; stores to 0x10, 0x14, 0x18, 0x1C -> count_o=4. Fifth store -> cpu_stall_o=1. Raise mem_ready_i -> memory receives 0x10..0x1C in order, then the fifth store.
- With entries {0x20=1, 0x20=2} buffered (macro off), lw 0x20 -> cpu_rdata_o=2. lw 0x24 -> mem_rdata_i. mem_we_o=0 during both loads.
- Buffer full, DRAIN with mem_ready_i=1 and a new store in the same cycle -> no stall, count_o stays 4, head and tail wrap correctly past index 3.
- Assert rst_n low with 3 entries buffered and mem_ready_i=0 -> count_o=0 immediately (async), mem_we_o=0, no further writes.
- STORE_BUF_COALESCE_EN defined, mem_ready_i=0: sw 0x40=5 then sw 0x40=9 -> count_o=1, and the drained write is 0x40=9.
